vdp18_access_sched: RTL and testbench

- Per-slot VRAM access scheduler for the VDP18 core: drives `access_type_o` and `spr_num_o` into the VRAM address multiplexer.
- Arbitrates free slots to the CPU port with a req/ack handshake.
- Runs the sprite-test scan and stores the sprite list used by the sprite fetch slots.
- Sits between the horizontal/vertical timing block and the address mux.

---
 rtl/vdp18_access_sched.sv | 211 +++++++++++++++++++++
 tb/tb_vdp18_access_sched.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vdp18_access_sched.sv
// VDP18 per-slot VRAM access scheduler: picks the access type of every slot,
// grants free slots to the CPU and runs the per-line sprite test that feeds
// the sprite fetch slots.
package vdp18_pkg;
  typedef enum logic [1:0] {GRAPH1, GRAPH2, MULTIC, TEXTM} opmode_t;
  typedef enum logic [3:0] {
    AC_NONE, AC_CPU, AC_PNT, AC_PCT, AC_PGT, AC_STST,
    AC_SATY, AC_SATX, AC_SATN, AC_SATC, AC_SPTH, AC_SPTL
  } access_t;
endpackage

module vdp18_access_sched
  import vdp18_pkg::*;
#(
  parameter int NUM_SLOTS = 171,
  parameter int SPR_MAX   = 4
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       clk_en_acc_i,
  input  logic       line_start_i,
  input  opmode_t    opmode_i,
  input  logic       vert_active_i,
  input  logic       blank_i,
  input  logic       cpu_req_i,
  output logic       cpu_ack_o,
  input  logic       spr_hit_i,
  input  logic       spr_term_i,
  output access_t    access_type_o,
  output logic [4:0] spr_num_o,
  output logic       spr_5th_o,
  output logic [4:0] spr_5th_num_o
);

  localparam int SLOT_W = $clog2(NUM_SLOTS);
  localparam int CNT_W  = $clog2(SPR_MAX + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_DONE} stst_t;

  logic [SLOT_W-1:0] slot_q, slot_nx;
  logic              ovr_q, ovr_nx;
  logic              gap_q, gap_nx;
  stst_t             st_q, st_nx;
  logic [CNT_W-1:0]  found_q, found_nx;
  logic [4:0]        list_q  [SPR_MAX];
  logic [4:0]        list_nx [SPR_MAX];
  logic              spr_5th_nx;
  logic [4:0]        spr_5th_num_nx;
  access_t           type_nx;
  logic [4:0]        num_nx;

  logic              graph;
  logic              eligible;
  logic              block;
  logic [4:0]        grp;
  logic [SLOT_W-1:0] off, k, sub, mod3;

  // The ack is tied to the strobe that closes an AC_CPU slot; gating with
  // reset drops a grant that is interrupted by reset.
  assign cpu_ack_o = clk_en_acc_i & reset_n_i & (access_type_o == AC_CPU);

  // Next-slot decode: slot counter, sprite test FSM, list and access type.
  always_comb begin
    slot_nx        = slot_q;
    ovr_nx         = ovr_q;
    gap_nx         = gap_q;
    st_nx          = st_q;
    found_nx       = found_q;
    list_nx        = list_q;
    spr_5th_nx     = spr_5th_o;
    spr_5th_num_nx = spr_5th_num_o;
    type_nx        = access_type_o;
    num_nx         = spr_num_o;
    graph          = (opmode_i != TEXTM);
    eligible       = 1'b0;
    block          = 1'b0;
    grp            = '0;
    off            = '0;
    k              = '0;
    sub            = '0;
    mod3           = '0;

    if (clk_en_acc_i) begin
      if (line_start_i || slot_q == SLOT_W'(NUM_SLOTS - 1)) slot_nx = '0;
      else slot_nx = slot_q + 1'b1;

      // Result of the sprite just tested arrives with the strobe closing its slot.
      if (access_type_o == AC_STST && st_q == ST_ACTIVE) begin
        if (spr_term_i) begin
          st_nx = ST_DONE;
        end else if (spr_hit_i && found_q < CNT_W'(SPR_MAX)) begin
          for (int i = 0; i < SPR_MAX; i++)
            if (found_q == CNT_W'(i)) list_nx[i] = spr_num_o;
          found_nx = found_q + 1'b1;
          if (spr_num_o == 5'd31) st_nx = ST_DONE;
        end else if (spr_hit_i) begin
          spr_5th_nx     = 1'b1;
          spr_5th_num_nx = spr_num_o;
          st_nx          = ST_DONE;
        end else if (spr_num_o == 5'd31) begin
          st_nx = ST_DONE;
        end
      end

      // A test cannot survive a switch to text mode.
      if (!graph && st_nx == ST_ACTIVE) st_nx = ST_DONE;

      // Line start: latch the whole-line override and arm a new sprite test.
      if (slot_nx == '0) begin
        ovr_nx = blank_i | ~vert_active_i;
        if (graph && !ovr_nx) begin
          st_nx      = ST_ACTIVE;
          found_nx   = '0;
          spr_5th_nx = 1'b0;
          for (int i = 0; i < SPR_MAX; i++) list_nx[i] = '0;
        end else begin
          st_nx = ST_IDLE;
        end
      end

      type_nx = AC_NONE;
      num_nx  = '0;
      if (ovr_nx) begin
        eligible = 1'b1;
      end else if (graph) begin
        if (slot_nx < SLOT_W'(128)) begin
          grp = slot_nx[6:2];
          case (slot_nx[1:0])
            2'd0: type_nx = AC_PNT;
            2'd1: if (opmode_i == MULTIC) eligible = 1'b1; else type_nx = AC_PCT;
            2'd2: type_nx = AC_PGT;
            default: begin
              if (st_nx == ST_ACTIVE) begin
                type_nx = AC_STST;
                num_nx  = grp;
              end else begin
                eligible = 1'b1;
              end
            end
          endcase
        end else if (slot_nx < SLOT_W'(152)) begin
          off = slot_nx - SLOT_W'(128);
          k   = off / SLOT_W'(6);
          sub = off % SLOT_W'(6);
          if (k < SLOT_W'(found_nx)) begin
            case (sub)
              SLOT_W'(0): type_nx = AC_SATY;
              SLOT_W'(1): type_nx = AC_SATX;
              SLOT_W'(2): type_nx = AC_SATN;
              SLOT_W'(3): type_nx = AC_SATC;
              SLOT_W'(4): type_nx = AC_SPTH;
              default:    type_nx = AC_SPTL;
            endcase
            for (int i = 0; i < SPR_MAX; i++)
              if (k == SLOT_W'(i)) num_nx = list_nx[i];
          end else begin
            eligible = 1'b1;
          end
        end else begin
          eligible = 1'b1;
        end
      end else begin
        if (slot_nx < SLOT_W'(120)) begin
          mod3 = slot_nx % SLOT_W'(3);
          if (mod3 == SLOT_W'(0)) type_nx = AC_PNT;
          else if (mod3 == SLOT_W'(1)) type_nx = AC_PGT;
          else eligible = 1'b1;
        end else begin
          eligible = 1'b1;
        end
      end

      // After an ack the next free slot is withheld so the requester can drop req.
      block = (access_type_o == AC_CPU) | gap_q;
      if (eligible) begin
        if (cpu_req_i && !block) type_nx = AC_CPU;
        gap_nx = 1'b0;
      end else begin
        gap_nx = block;
      end
    end
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      slot_q        <= '0;
      ovr_q         <= 1'b0;
      gap_q         <= 1'b0;
      st_q          <= ST_IDLE;
      found_q       <= '0;
      for (int i = 0; i < SPR_MAX; i++) list_q[i] <= '0;
      access_type_o <= AC_NONE;
      spr_num_o     <= '0;
      spr_5th_o     <= 1'b0;
      spr_5th_num_o <= '0;
    end else begin
      slot_q        <= slot_nx;
      ovr_q         <= ovr_nx;
      gap_q         <= gap_nx;
      st_q          <= st_nx;
      found_q       <= found_nx;
      list_q        <= list_nx;
      access_type_o <= type_nx;
      spr_num_o     <= num_nx;
      spr_5th_o     <= spr_5th_nx;
      spr_5th_num_o <= spr_5th_num_nx;
    end
  end

endmodule

// File: tb/tb_vdp18_access_sched.sv
// Bench for vdp18_access_sched: a line-level model predicts every slot.
module tb_vdp18_access_sched;
  import vdp18_pkg::*;

  localparam int NS = 171;

  logic       clk = 1'b0;
  logic       reset_n_i, clk_en_acc_i, line_start_i, vert_active_i, blank_i;
  logic       cpu_req_i, cpu_ack_o, spr_hit_i, spr_term_i, spr_5th_o;
  opmode_t    opmode_i;
  access_t    access_type_o;
  logic [4:0] spr_num_o, spr_5th_num_o;

  always #5 clk = ~clk;

  vdp18_access_sched #(.NUM_SLOTS(NS), .SPR_MAX(4)) dut (
    .clk_i(clk), .reset_n_i(reset_n_i), .clk_en_acc_i(clk_en_acc_i),
    .line_start_i(line_start_i), .opmode_i(opmode_i), .vert_active_i(vert_active_i),
    .blank_i(blank_i), .cpu_req_i(cpu_req_i), .cpu_ack_o(cpu_ack_o),
    .spr_hit_i(spr_hit_i), .spr_term_i(spr_term_i), .access_type_o(access_type_o),
    .spr_num_o(spr_num_o), .spr_5th_o(spr_5th_o), .spr_5th_num_o(spr_5th_num_o));

  // Line configuration
  opmode_t    l_mode;
  bit         l_blank, l_vert, l_req;
  bit [31:0]  l_hits;
  int         l_term;
  // Model state carried across lines
  bit         m_prev_grant, m_5th;
  logic [4:0] m_5th_num;
  int         m_found, m_g5;
  int         m_list [4];
  access_t    exp_type    [NS];
  logic [4:0] exp_num     [NS];
  logic       exp_5th     [NS];
  logic [4:0] exp_5th_num [NS];

  int  phase = 0;
  int  cur_slot = 0;
  bit  ack_exp = 1'b0;
  bit  cur_cpu = 1'b0;
  int  n_checks = 0;
  int  n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_line(input opmode_t m, input bit b, input bit v, input bit r,
                          input bit [31:0] h, input int t);
    l_mode = m; l_blank = b; l_vert = v; l_req = r; l_hits = h; l_term = t;
  endtask

  // Whole-line prediction from the scheduling rules.
  task automatic build_line();
    access_t sat_seq [6] = '{AC_SATY, AC_SATX, AC_SATN, AC_SATC, AC_SPTH, AC_SPTL};
    bit ovr, graph, active, elig;
    int last_g, g, k, n;
    access_t t;
    ovr    = l_blank || !l_vert;
    graph  = (l_mode != TEXTM);
    active = graph && !ovr;
    m_found = 0; m_g5 = -1; last_g = 31;
    for (int i = 0; i < 4; i++) m_list[i] = 0;
    if (active) begin
      for (int gg = 0; gg < 32; gg++) begin
        if (gg == l_term) begin last_g = gg; break; end
        if (l_hits[gg]) begin
          if (m_found < 4) begin m_list[m_found] = gg; m_found++; end
          else begin m_g5 = gg; last_g = gg; break; end
        end
      end
    end
    for (int s = 0; s < NS; s++) begin
      t = AC_NONE; n = 0; elig = 1'b0;
      if (ovr) elig = 1'b1;
      else if (graph) begin
        if (s < 128) begin
          g = s / 4;
          case (s % 4)
            0: t = AC_PNT;
            1: if (l_mode == MULTIC) elig = 1'b1; else t = AC_PCT;
            2: t = AC_PGT;
            default: if (active && g <= last_g) begin t = AC_STST; n = g; end else elig = 1'b1;
          endcase
        end else if (s < 152) begin
          k = (s - 128) / 6;
          if (k < m_found) begin t = sat_seq[(s - 128) % 6]; n = m_list[k]; end
          else elig = 1'b1;
        end else elig = 1'b1;
      end else begin
        if (s < 120) begin
          if (s % 3 == 0) t = AC_PNT;
          else if (s % 3 == 1) t = AC_PGT;
          else elig = 1'b1;
        end else elig = 1'b1;
      end
      if (elig) begin
        if (l_req && !m_prev_grant) begin t = AC_CPU; m_prev_grant = 1'b1; end
        else m_prev_grant = 1'b0;
      end
      exp_type[s] = t;
      exp_num[s]  = 5'(n);
      if (active) begin
        if (m_g5 >= 0 && s >= 4 * m_g5 + 4) begin exp_5th[s] = 1'b1; exp_5th_num[s] = 5'(m_g5); end
        else begin exp_5th[s] = 1'b0; exp_5th_num[s] = m_5th_num; end
      end else begin
        exp_5th[s] = m_5th; exp_5th_num[s] = m_5th_num;
      end
    end
    if (active) begin
      m_5th = (m_g5 >= 0);
      if (m_g5 >= 0) m_5th_num = 5'(m_g5);
    end
  endtask

  // Drive nslots strobes from slot 0; each strobe is followed by a quiet cycle.
  task automatic run_line(input int nslots);
    int es;
    for (int s = 0; s < nslots; s++) begin
      @(posedge clk); #2;
      ack_exp = cur_cpu;
      if (s == 0) begin
        build_line();
        opmode_i = l_mode; blank_i = l_blank; vert_active_i = l_vert;
      end
      spr_hit_i = 1'b0; spr_term_i = 1'b0;
      if (s > 0) begin
        es = s - 1;
        if (es < 128 && es % 4 == 3) begin
          spr_hit_i  = l_hits[es / 4];
          spr_term_i = ((es / 4) == l_term);
        end
      end
      cpu_req_i = l_req; clk_en_acc_i = 1'b1; line_start_i = (s == 0); phase = 1;
      @(posedge clk); #2;
      clk_en_acc_i = 1'b0; line_start_i = 1'b0; spr_hit_i = 1'b0; spr_term_i = 1'b0;
      cur_slot = s; cur_cpu = (exp_type[s] == AC_CPU); phase = 2;
    end
  endtask

  // Compare process: ack on strobe cycles, slot outputs on quiet cycles.
  always @(negedge clk) begin
    if (phase == 1) begin
      chk($sformatf("ack_end_slot%0d", cur_slot), cpu_ack_o, ack_exp);
    end else if (phase == 2) begin
      chk($sformatf("type_slot%0d", cur_slot), access_type_o, exp_type[cur_slot]);
      chk($sformatf("num_slot%0d", cur_slot), spr_num_o, exp_num[cur_slot]);
      chk($sformatf("5th_slot%0d", cur_slot), spr_5th_o, exp_5th[cur_slot]);
      chk($sformatf("5thnum_slot%0d", cur_slot), spr_5th_num_o, exp_5th_num[cur_slot]);
      chk($sformatf("ack_quiet_slot%0d", cur_slot), cpu_ack_o, 0);
    end
  end

  task automatic reset_strobe(input string tag);
    @(posedge clk); #2;
    reset_n_i = 1'b0; clk_en_acc_i = 1'b1; cpu_req_i = 1'b1;
    @(negedge clk);
    chk({tag, "_ack"}, cpu_ack_o, 0);
    @(posedge clk); #2;
    clk_en_acc_i = 1'b0;
    @(negedge clk);
    chk({tag, "_type"}, access_type_o, AC_NONE);
    chk({tag, "_num"}, spr_num_o, 0);
    chk({tag, "_5th"}, spr_5th_o, 0);
    chk({tag, "_5thnum"}, spr_5th_num_o, 0);
  endtask

  initial begin
    int cnt;
    reset_n_i = 1'b0; clk_en_acc_i = 1'b0; line_start_i = 1'b0; opmode_i = GRAPH1;
    vert_active_i = 1'b1; blank_i = 1'b0; cpu_req_i = 1'b1; spr_hit_i = 1'b0; spr_term_i = 1'b0;
    m_prev_grant = 1'b0; m_5th = 1'b0; m_5th_num = '0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 3; i++) reset_strobe("reset");
    @(posedge clk); #2; reset_n_i = 1'b1; cpu_req_i = 1'b0;

    // GRAPH1, terminator on the first test
    set_line(GRAPH1, 0, 1, 0, 32'h0, 0); run_line(NS);
    chk("pin_l1_s0", exp_type[0], AC_PNT);   chk("pin_l1_s1", exp_type[1], AC_PCT);
    chk("pin_l1_s2", exp_type[2], AC_PGT);   chk("pin_l1_s3", exp_type[3], AC_STST);
    chk("pin_l1_s7", exp_type[7], AC_NONE);  chk("pin_l1_s11", exp_type[11], AC_NONE);
    chk("pin_l1_s128", exp_type[128], AC_NONE); chk("pin_l1_s151", exp_type[151], AC_NONE);

    // TEXTM CPU handshake
    set_line(TEXTM, 0, 1, 1, 32'h0, -1); run_line(NS);
    chk("pin_l2_s2", exp_type[2], AC_CPU); chk("pin_l2_s5", exp_type[5], AC_NONE);
    chk("pin_l2_s8", exp_type[8], AC_CPU);

    // Five hits: 5th sprite flag
    set_line(GRAPH1, 0, 1, 0, (32'd1 << 2) | (32'd1 << 5) | (32'd1 << 9) | (32'd1 << 20) | (32'd1 << 25), -1);
    run_line(NS);
    chk("pin_l3_list0", m_list[0], 2);  chk("pin_l3_list1", m_list[1], 5);
    chk("pin_l3_list2", m_list[2], 9);  chk("pin_l3_list3", m_list[3], 20);
    chk("pin_l3_s128", exp_type[128], AC_SATY); chk("pin_l3_n128", exp_num[128], 2);
    chk("pin_l3_s133", exp_type[133], AC_SPTL); chk("pin_l3_s146", exp_type[146], AC_SATY);
    chk("pin_l3_n146", exp_num[146], 20);
    chk("pin_l3_5th103", exp_5th[103], 0); chk("pin_l3_5th104", exp_5th[104], 1);
    chk("pin_l3_5thnum", exp_5th_num[170], 25);

    // Partial list: two hits then terminator at g=6
    set_line(GRAPH2, 0, 1, 1, (32'd1 << 1) | (32'd1 << 3), 6); run_line(NS);
    chk("pin_l4_s27", exp_type[27], AC_STST); chk("pin_l4_s31", exp_type[31] != AC_STST, 1);
    chk("pin_l4_s134", exp_type[134], AC_SATY); chk("pin_l4_n134", exp_num[134], 3);
    chk("pin_l4_s140", exp_type[140] == AC_CPU || exp_type[140] == AC_NONE, 1);
    chk("pin_l4_s151", exp_type[151] == AC_CPU || exp_type[151] == AC_NONE, 1);

    // MULTIC, single hit on the last tested sprite
    set_line(MULTIC, 0, 1, 1, 32'h8000_0000, -1); run_line(NS);
    chk("pin_l5_s128", exp_type[128], AC_SATY); chk("pin_l5_n128", exp_num[128], 31);
    chk("pin_l5_s134", exp_type[134] == AC_CPU || exp_type[134] == AC_NONE, 1);

    // Blank line
    set_line(GRAPH1, 1, 1, 1, 32'hFFFF_FFFF, -1); run_line(NS);
    cnt = 0;
    for (int s = 0; s < NS; s++) if (exp_type[s] != AC_CPU && exp_type[s] != AC_NONE) cnt++;
    chk("pin_l6_only_cpu", cnt, 0);

    // Hits 0..4 set the flag, then text and inactive lines hold it
    set_line(GRAPH1, 0, 1, 0, 32'h0000_001F, -1); run_line(NS);
    chk("pin_l7_5thnum", exp_5th_num[170], 4);
    set_line(TEXTM, 0, 1, 0, 32'hFFFF_FFFF, -1); run_line(NS);
    chk("pin_l8_5th", exp_5th[0], 1);
    set_line(GRAPH2, 0, 0, 0, 32'hFFFF_FFFF, -1); run_line(NS);

    // Terminator and hit together: terminator wins
    set_line(GRAPH1, 0, 1, 0, 32'h1, 0); run_line(NS);
    chk("pin_l10_s3", exp_type[3], AC_STST); chk("pin_l10_s128", exp_type[128], AC_NONE);
    chk("pin_l10_5th", exp_5th[170], 0);

    // Reset while a CPU slot is in progress
    set_line(GRAPH1, 1, 1, 1, 32'h0, -1); run_line(3);
    chk("pin_l11_slot2_cpu", cur_cpu, 1);
    phase = 0;
    reset_strobe("midreset");
    m_prev_grant = 1'b0; m_5th = 1'b0; m_5th_num = '0; cur_cpu = 1'b0;
    @(posedge clk); #2; reset_n_i = 1'b1;
    set_line(GRAPH1, 1, 1, 1, 32'h0, -1); run_line(NS);

    // Close the last slot to check its ack
    @(posedge clk); #2;
    ack_exp = cur_cpu; clk_en_acc_i = 1'b1; line_start_i = 1'b1; phase = 1;
    @(posedge clk); #2;
    clk_en_acc_i = 1'b0; line_start_i = 1'b0; phase = 0;
    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
